// File: rtl/modul_acumulator_diferente.sv
// Frame accumulator for the difference stream.
// Sums FRAME_LEN signed samples with saturation and hands off one result per frame.
module modul_acumulator_diferente #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_diff,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FRAME_LEN) + 1;

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ACCUM,
    OUT
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum_full;
  logic [CNT_W-1:0] cnt;
  logic             sat_sticky;
  logic             sat_hit;
  logic             take;
  logic             last;

  assign in_ready = (state == ACCUM);
  assign take     = in_valid && in_ready;
  assign last     = (cnt == CNT_W'(FRAME_LEN - 1));

  // One guard bit: overflow shows as the top two bits disagreeing.
  always_comb begin
    sum_full = {acc[ACC_W-1], acc}
             + {{(ACC_W+1-DATA_W){in_diff[DATA_W-1]}}, in_diff};
    acc_next = sum_full[ACC_W-1:0];
    sat_hit  = 1'b0;
    if (sum_full[ACC_W] != sum_full[ACC_W-1]) begin
      sat_hit  = 1'b1;
      acc_next = sum_full[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
      out_sum    <= '0;
      out_sat    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            if (last) begin
              out_sum    <= acc_next;
              out_sat    <= sat_sticky | sat_hit;
              out_valid  <= 1'b1;
              acc        <= '0;
              cnt        <= '0;
              sat_sticky <= 1'b0;
              state      <= OUT;
            end else begin
              acc        <= acc_next;
              sat_sticky <= sat_sticky | sat_hit;
              cnt        <= cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_modul_acumulator_diferente.sv
// Scoreboard bench for modul_acumulator_diferente.
// Three instances: defaults, ACC_W=8, FRAME_LEN=1.
module tb_modul_acumulator_diferente;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_diff = '0;
  logic [2:0]  vld = '0;
  logic [2:0]  rdy;
  logic        out_ready = 1'b1;

  logic [15:0] os0, os2;
  logic [7:0]  os1;
  logic        osat0, osat1, osat2;
  logic        ov0, ov1, ov2;

  int n_vec = 0;
  int n_err = 0;
  int hs0 = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  logic [16:0] e0, e1, e2;

  always #5 clk = ~clk;

  modul_acumulator_diferente u0 (
    .clk(clk), .rst_n(rst_n),
    .in_diff(in_diff), .in_valid(vld[0]),
    .in_ready(rdy[0]), .out_sum(os0),
    .out_sat(osat0), .out_valid(ov0),
    .out_ready(out_ready)
  );

  modul_acumulator_diferente #(.ACC_W(8)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_diff(in_diff), .in_valid(vld[1]),
    .in_ready(rdy[1]), .out_sum(os1),
    .out_sat(osat1), .out_valid(ov1),
    .out_ready(out_ready)
  );

  modul_acumulator_diferente #(.FRAME_LEN(1)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_diff(in_diff), .in_valid(vld[2]),
    .in_ready(rdy[2]), .out_sum(os2),
    .out_sat(osat2), .out_valid(ov2),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are observed mid-cycle, where inputs are stable.
  always @(negedge clk) begin
    if (rst_n && ov0 && out_ready) begin
      hs0++;
      if (q0.size() == 0) chk("sb0_extra", q0.size(), 1);
      else begin
        e0 = q0.pop_front();
        chk("sb0_sum", os0, e0[15:0]);
        chk("sb0_sat", osat0, e0[16]);
      end
    end
    if (rst_n && ov1 && out_ready) begin
      if (q1.size() == 0) chk("sb1_extra", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("sb1_sum", {{8{os1[7]}}, os1}, e1[15:0]);
        chk("sb1_sat", osat1, e1[16]);
      end
    end
    if (rst_n && ov2 && out_ready) begin
      if (q2.size() == 0) chk("sb2_extra", q2.size(), 1);
      else begin
        e2 = q2.pop_front();
        chk("sb2_sum", os2, e2[15:0]);
        chk("sb2_sat", osat2, e2[16]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted.
  task automatic send(input int id, input int val);
    int b;
    b = 0;
    in_diff = 8'(val);
    vld[id] = 1'b1;
    while (!rdy[id] && b < 50) begin
      tick(1);
      b++;
    end
    if (b >= 50) chk("send_timeout", b, 0);
    tick(1);
    vld[id] = 1'b0;
  endtask

  initial begin
    #23;
    chk("rst_ov", ov0, 0);
    chk("rst_sum", os0, 0);
    chk("rst_sat", osat0, 0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_rdy", rdy[0], 1);

    // basic sum
    q0.push_back({1'b0, 16'd9});
    send(0, 3); send(0, -1); send(0, 5); send(0, 2);
    chk("basic_ov", ov0, 1);
    chk("basic_rdy0", rdy[0], 0);
    tick(1);
    chk("basic_rdy1", rdy[0], 1);
    chk("basic_ovlo", ov0, 0);

    // input gaps
    q0.push_back({1'b0, 16'hFFFE});
    send(0, 10); tick(2);
    send(0, -20); tick(2);
    send(0, 7); tick(2);
    send(0, 1);
    tick(4);
    chk("gap_pulses", hs0, 2);

    // backpressure
    out_ready = 1'b0;
    q0.push_back({1'b0, 16'd9});
    send(0, 3); send(0, -1); send(0, 5); send(0, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", ov0, 1);
      chk("bp_sum", os0, 9);
      chk("bp_rdy", rdy[0], 0);
      tick(1);
    end
    out_ready = 1'b1;
    q0.push_back({1'b0, 16'd4});
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    tick(3);
    chk("bp_hs", hs0, 4);

    // saturation, ACC_W = 8
    q1.push_back({1'b1, 16'h007F});
    for (int i = 0; i < 4; i++) send(1, 127);
    q1.push_back({1'b1, 16'hFF80});
    for (int i = 0; i < 4; i++) send(1, -128);
    q1.push_back({1'b0, 16'd4});
    for (int i = 0; i < 4; i++) send(1, 1);
    tick(3);

    // reset mid-frame
    send(0, 50); send(0, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ov", ov0, 0);
    chk("mrst_sum", os0, 0);
    chk("mrst_sat1", osat1, 0);
    #2 rst_n = 1'b1;
    tick(1);
    q0.push_back({1'b0, 16'd10});
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    tick(3);

    // FRAME_LEN = 1
    q2.push_back({1'b0, 16'hFFFB});
    q2.push_back({1'b0, 16'd6});
    send(2, -5);
    chk("fl1_rdy_a", rdy[2], 0);
    chk("fl1_ov_a", ov2, 1);
    send(2, 6);
    chk("fl1_rdy_b", rdy[2], 0);
    tick(3);

    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modul_acumulator_diferente.md
# modul_acumulator_diferente

Downstream consumer of the pipeline's difference stage. Takes a stream of signed differences under a valid/ready handshake and sums each frame of FRAME_LEN samples into a saturating accumulator. It presents one frame sum per frame, with a per-frame saturation flag, on a valid/ready output. It is the stage that registers and reduces the difference results before the next pipeline consumer.

## Interface

Parameters:
- DATA_W, 8: width of the signed two's-complement input difference.
- ACC_W, 16: width of the signed accumulator and output sum. Must be ≥ DATA_W.
- FRAME_LEN, 4: number of samples per frame. Must be ≥ 1.
- CNT_W, derived as clog2(FRAME_LEN)+1: width of the internal sample counter. Not a port.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_diff, input, DATA_W: signed difference sample.
- in_valid, input, 1: in_diff is valid this cycle.
- in_ready, output, 1: block accepts a sample this cycle.
- out_sum, output, ACC_W: signed frame sum, saturated.
- out_sat, output, 1: saturation occurred at least once during this frame.
- out_valid, output, 1: out_sum and out_sat are valid.
- out_ready, input, 1: downstream accepts the output this cycle.

## Operation

- FSM has two states.
  - ACCUM: collecting samples.
  - OUT: holding a result until downstream takes it.
- in_ready = 1 in ACCUM, 0 in OUT. It is purely combinational from state.
- A sample is accepted when in_valid && in_ready.
- On each accepted sample in ACCUM:
  - sum_full = acc + sign_extend(in_diff), computed at ACC_W+1 bits.
  - If sum_full > 2^(ACC_W-1)-1: acc_next = 2^(ACC_W-1)-1 and sat_hit = 1.
  - If sum_full < -2^(ACC_W-1): acc_next = -2^(ACC_W-1) and sat_hit = 1.
  - Otherwise acc_next = sum_full and sat_hit = 0.
  - sat_sticky <= sat_sticky | sat_hit.
  - cnt <= cnt + 1.
- Accepting a sample when cnt == FRAME_LEN-1 closes the frame:
  - out_sum <= acc_next.
  - out_sat <= sat_sticky | sat_hit.
  - out_valid <= 1.
  - acc <= 0, cnt <= 0, sat_sticky <= 0.
  - State goes to OUT.
- In ACCUM with no accepted sample, all state holds. Gaps in in_valid are legal.
- In OUT, out_sum, out_sat and out_valid are stable. in_diff and in_valid are ignored.
- When out_valid && out_ready in OUT: out_valid <= 0 and state returns to ACCUM. out_sum and out_sat keep their last values.
- With FRAME_LEN = 1, every accepted sample closes a frame. out_sum is the sign-extended in_diff, saturated to ACC_W.

## Timing

- Reset values (asynchronous, while rst_n = 0):
  - State ACCUM; acc = 0; cnt = 0; sat_sticky = 0.
  - out_sum = 0; out_sat = 0; out_valid = 0.
  - in_ready = 1 on the first cycle after reset release.
- Latency: out_valid rises on the clock edge that accepts the last sample of a frame. It is visible the cycle after that sample is presented.
- Throughput: at best FRAME_LEN+1 cycles per frame, because in_ready drops for at least one cycle in OUT.
- Backpressure:
  - If out_ready is held low, the block stays in OUT indefinitely with the output held and in_ready = 0.
  - No input sample is lost or double-counted.
- out_valid, once high, stays high until the handshake completes. out_sum and out_sat do not change while out_valid = 1.
- Reset mid-frame or mid-OUT:
  - Partial accumulation, count and any pending output are discarded.
  - The next frame starts from cnt = 0, acc = 0.
- Saturation is per frame. The sticky flag clears at frame close, so the next frame starts unsaturated.
- Once saturated, later samples of opposite sign move acc off the rail normally. The flag stays set for that frame.

## Test plan

- **Basic sum:** defaults; in_valid = 1, out_ready = 1; samples 3, -1, 5, 2 → one cycle after the 4th sample, out_valid = 1, out_sum = 9, out_sat = 0; in_ready = 0 that cycle and 1 the next.
- **Input gaps:** samples 10, -20, 7, 1 with in_valid low for 2 cycles between each → out_sum = -2 (0xFFFE), out_sat = 0; exactly one out_valid pulse.
- **Backpressure:** complete a frame summing to 9 with out_ready = 0 for 5 cycles → out_valid, out_sum = 9 and in_ready = 0 held all 5 cycles. Raise out_ready → one handshake, then a frame 1, 1, 1, 1 gives out_sum = 4.
- **Saturation:** ACC_W = 8, DATA_W = 8.
  - Samples 127 ×4 → out_sum = 127, out_sat = 1.
  - Next frame -128 ×4 → out_sum = -128, out_sat = 1.
  - Next frame 1 ×4 → out_sum = 4, out_sat = 0.
- **Reset mid-frame:** accept 50, 50, then pulse rst_n low asynchronously between clock edges → out_valid = 0 and out_sum = 0 immediately. Then 1, 2, 3, 4 → out_sum = 10.
- **FRAME_LEN = 1:** samples -5, 6 back-to-back with out_ready = 1 → two results, -5 then 6. Each sample is followed by one cycle of in_ready = 0.
